// File: rtl/a2d_spi_resp.sv
// rtl/a2d_spi_resp.sv - SPI responder modelling an 8-channel 12-bit A2D
module a2d_spi_resp #(
  parameter int WIDTH       = 16,
  parameter int RES_BITS    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ss_n_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic [8*RES_BITS-1:0] ch_data_i,
  output logic                  cmd_rdy_o,
  output logic [2:0]            chnnl_o,
  output logic                  frm_err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  // Edges are only trusted once the synchronizer holds real samples, so a
  // level-low SS_n coming out of reset is not mistaken for a falling edge.
  logic [SYNC_STAGES:0]   vld_q;

  state_t                 state_q;
  logic [WIDTH-1:0]       rx_shft_q, tx_shft_q, res_q;
  logic [4:0]             bit_cnt_q;
  logic                   cmd_rdy_q, frm_err_q, busy_q;
  logic [2:0]             chnnl_q;

  logic                   sclk_s, ss_s, mosi_s, vld;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [WIDTH-1:0]       res_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign vld       = vld_q[SYNC_STAGES];
  assign sclk_rise = vld &  sclk_s & ~sclk_prev_q;
  assign sclk_fall = vld & ~sclk_s &  sclk_prev_q;
  assign ss_rise   = vld &  ss_s   & ~ss_prev_q;
  assign ss_fall   = vld & ~ss_s   &  ss_prev_q;

  // Synchronize the asynchronous SPI pins and keep one previous sample for edges
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      vld_q       <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      vld_q       <= {vld_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Select the requested channel, zero-extended to a full frame
  always_comb begin
    res_d = '0;
    for (int n = 0; n < 8; n++) begin
      if (rx_shft_q[13:11] == 3'(n)) begin
        res_d[RES_BITS-1:0] = ch_data_i[RES_BITS*n +: RES_BITS];
      end
    end
  end

  // Frame FSM: shift on synced SCLK edges, decode and load result at frame end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rx_shft_q <= '0;
      tx_shft_q <= '0;
      res_q     <= '0;
      bit_cnt_q <= '0;
      chnnl_q   <= '0;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          // SS_n rise takes priority; a coincident SCLK edge is dropped
          if (ss_rise) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            if (bit_cnt_q == 5'(WIDTH)) begin
              chnnl_q   <= rx_shft_q[13:11];
              tx_shft_q <= res_d;
              res_q     <= res_d;
              cmd_rdy_q <= 1'b1;
            end else begin
              // A bad frame re-arms the last good result for the next frame
              tx_shft_q <= res_q;
              frm_err_q <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_shft_q <= {rx_shft_q[WIDTH-2:0], mosi_s};
            if (bit_cnt_q != 5'd31) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end else if (sclk_fall) begin
            tx_shft_q <= {tx_shft_q[WIDTH-2:0], 1'b0};
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign miso_o    = ~ss_s & tx_shft_q[WIDTH-1];
  assign cmd_rdy_o = cmd_rdy_q;
  assign frm_err_o = frm_err_q;
  assign chnnl_o   = chnnl_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// tb/tb_a2d_spi_resp.sv - directed self-checking bench for a2d_spi_resp
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic [95:0] ch_data = '0;
  logic        miso, cmd_rdy, frm_err, busy;
  logic [2:0]  chnnl;

  int n_pass = 0;
  int n_total = 0;
  int n_cmd = 0;
  int n_err = 0;
  int last_lat = 0;
  bit busy_seen = 1'b0;
  bit chg_en = 1'b0;
  logic [95:0] chg_val = '0;

  a2d_spi_resp #(.WIDTH(16), .RES_BITS(12), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .ss_n_i(ss_n), .sclk_i(sclk), .mosi_i(mosi),
    .miso_o(miso), .ch_data_i(ch_data), .cmd_rdy_o(cmd_rdy), .chnnl_o(chnnl),
    .frm_err_o(frm_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Count pulse cycles; a one-clk pulse adds exactly one
  always @(negedge clk) begin
    if (cmd_rdy) n_cmd++;
    if (frm_err) n_err++;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int n, input logic [11:0] v);
    ch_data[12*n +: 12] = v;
  endtask

  task automatic sbit(input logic b, output logic m);
    mosi = b;
    clk_n(8);
    m = miso;
    if (busy) busy_seen = 1'b1;
    sclk = 1'b1;
    clk_n(8);
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [15:0] cmd, input int nbits, output logic [15:0] rd);
    logic m;
    rd = '0;
    last_lat = 0;
    busy_seen = 1'b0;
    ss_n = 1'b0;
    clk_n(8);
    for (int i = 0; i < nbits; i++) begin
      sbit((i < 16) ? cmd[15-i] : 1'b0, m);
      if (i < 16) rd[15-i] = m;
    end
    clk_n(8);
    ss_n = 1'b1;
    mosi = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (cmd_rdy && last_lat == 0) last_lat = k;
      if (chg_en && last_lat != 0 && k == last_lat + 1) begin
        ch_data = chg_val;
        chg_en = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clk_n(3);
    n_total++; if (miso !== 1'b0) $display("FAIL rst_miso: got %b expected 0", miso); else n_pass++;
    n_total++; if (cmd_rdy !== 1'b0) $display("FAIL rst_cmd_rdy: got %b expected 0", cmd_rdy); else n_pass++;
    n_total++; if (frm_err !== 1'b0) $display("FAIL rst_frm_err: got %b expected 0", frm_err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (chnnl !== 3'd0) $display("FAIL rst_chnnl: got %0d expected 0", chnnl); else n_pass++;
    rst = 1'b0;
    clk_n(5);
  endtask

  task automatic test_single;
    logic [15:0] rd;
    int c0, e0;
    set_ch(2, 12'hA5C);
    set_ch(0, 12'h111);
    c0 = n_cmd; e0 = n_err;
    frame(16'h1000, 16, rd);
    n_total++; if (rd !== 16'h0000) $display("FAIL first_frame: got %h expected 0000", rd); else n_pass++;
    n_total++; if (n_cmd - c0 !== 1) $display("FAIL single_cmd_rdy: got %0d pulses expected 1", n_cmd - c0); else n_pass++;
    n_total++; if (n_err - e0 !== 0) $display("FAIL single_frm_err: got %0d pulses expected 0", n_err - e0); else n_pass++;
    n_total++; if (chnnl !== 3'd2) $display("FAIL single_chnnl: got %0d expected 2", chnnl); else n_pass++;
    n_total++; if (last_lat < 1 || last_lat > 4) $display("FAIL cmd_rdy_latency: got %0d expected 1..4", last_lat); else n_pass++;
    n_total++; if (busy_seen !== 1'b1) $display("FAIL busy_in_frame: got %b expected 1", busy_seen); else n_pass++;
    frame(16'h0000, 16, rd);
    n_total++; if (rd !== 16'h0A5C) $display("FAIL single_result: got %h expected 0A5C", rd); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd;
    set_ch(7, 12'hFFF);
    set_ch(0, 12'h001);
    frame(16'h3800, 16, rd);
    n_total++; if (rd !== 16'h0111) $display("FAIL b2b_prev: got %h expected 0111", rd); else n_pass++;
    n_total++; if (chnnl !== 3'd7) $display("FAIL b2b_chnnl7: got %0d expected 7", chnnl); else n_pass++;
    frame(16'h0000, 16, rd);
    n_total++; if (rd !== 16'h0FFF) $display("FAIL b2b_ch7: got %h expected 0FFF", rd); else n_pass++;
    frame(16'h0000, 16, rd);
    n_total++; if (rd !== 16'h0001) $display("FAIL b2b_ch0: got %h expected 0001", rd); else n_pass++;
    n_total++; if (chnnl !== 3'd0) $display("FAIL b2b_chnnl0: got %0d expected 0", chnnl); else n_pass++;
  endtask

  task automatic test_short_frame;
    logic [15:0] rd;
    int c0, e0;
    set_ch(5, 12'h3C7);
    c0 = n_cmd; e0 = n_err;
    frame(16'h2800, 9, rd);
    n_total++; if (n_err - e0 !== 1) $display("FAIL short_frm_err: got %0d pulses expected 1", n_err - e0); else n_pass++;
    n_total++; if (n_cmd - c0 !== 0) $display("FAIL short_cmd_rdy: got %0d pulses expected 0", n_cmd - c0); else n_pass++;
    n_total++; if (chnnl !== 3'd0) $display("FAIL short_chnnl: got %0d expected 0", chnnl); else n_pass++;
    frame(16'h0000, 16, rd);
    n_total++; if (rd !== 16'h0001) $display("FAIL short_next: got %h expected 0001", rd); else n_pass++;
  endtask

  task automatic test_long_frame;
    logic [15:0] rd;
    int c0, e0;
    c0 = n_cmd; e0 = n_err;
    frame(16'h2800, 17, rd);
    n_total++; if (n_err - e0 !== 1) $display("FAIL long_frm_err: got %0d pulses expected 1", n_err - e0); else n_pass++;
    n_total++; if (n_cmd - c0 !== 0) $display("FAIL long_cmd_rdy: got %0d pulses expected 0", n_cmd - c0); else n_pass++;
    n_total++; if (rd !== 16'h0001) $display("FAIL long_data: got %h expected 0001", rd); else n_pass++;
    n_total++; if (chnnl !== 3'd0) $display("FAIL long_chnnl: got %0d expected 0", chnnl); else n_pass++;
  endtask

  task automatic test_rst_mid_frame;
    logic [15:0] rd;
    logic [15:0] cmd;
    logic m;
    int c0, e0;
    cmd = 16'h2800;
    ss_n = 1'b0;
    clk_n(8);
    for (int i = 0; i < 8; i++) sbit(cmd[15-i], m);
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
    clk_n(6);
    n_total++; if (miso !== 1'b0) $display("FAIL rstmid_miso: got %b expected 0", miso); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    c0 = n_cmd; e0 = n_err;
    busy_seen = 1'b0;
    for (int i = 8; i < 16; i++) sbit(cmd[15-i], m);
    clk_n(8);
    ss_n = 1'b1;
    clk_n(12);
    n_total++; if (busy_seen !== 1'b0) $display("FAIL rstmid_ignored_busy: got %b expected 0", busy_seen); else n_pass++;
    n_total++; if ((n_cmd - c0) + (n_err - e0) !== 0) $display("FAIL rstmid_no_pulse: got %0d pulses expected 0", (n_cmd - c0) + (n_err - e0)); else n_pass++;
    frame(16'h2800, 16, rd);
    n_total++; if (rd !== 16'h0000) $display("FAIL rstmid_cleared: got %h expected 0000", rd); else n_pass++;
    n_total++; if (n_cmd - c0 !== 1) $display("FAIL rstmid_cmd_rdy: got %0d pulses expected 1", n_cmd - c0); else n_pass++;
    n_total++; if (chnnl !== 3'd5) $display("FAIL rstmid_chnnl: got %0d expected 5", chnnl); else n_pass++;
    frame(16'h0000, 16, rd);
    n_total++; if (rd !== 16'h03C7) $display("FAIL rstmid_result: got %h expected 03C7", rd); else n_pass++;
  endtask

  task automatic test_ch_data_hold;
    logic [15:0] rd;
    set_ch(3, 12'h123);
    chg_val = ch_data;
    chg_val[36 +: 12] = 12'hEEE;
    chg_en = 1'b1;
    frame(16'h1800, 16, rd);
    n_total++; if (chnnl !== 3'd3) $display("FAIL hold_chnnl: got %0d expected 3", chnnl); else n_pass++;
    n_total++; if (ch_data[36 +: 12] !== 12'hEEE) $display("FAIL hold_stim_applied: got %h expected EEE", ch_data[36 +: 12]); else n_pass++;
    frame(16'h0000, 16, rd);
    n_total++; if (rd !== 16'h0123) $display("FAIL hold_result: got %h expected 0123", rd); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_short_frame;
    test_long_frame;
    test_rst_mid_frame;
    test_ch_data_hold;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
